// File: rtl/dac_comp_array.sv
// Multi-channel P/M 1-bit DAC pairs (PWM or first-order sigma-delta) with a
// per-period ones comparator, driven from one shared prescaler and phase counter.
module dac_comp_array #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int PRESCALE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      mode,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [CHANNELS*WIDTH-1:0] code_p,
    input  logic [CHANNELS*WIDTH-1:0] code_m,
    output logic [CHANNELS-1:0]       dac_p,
    output logic [CHANNELS-1:0]       dac_m,
    output logic [CHANNELS-1:0]       cmp_out,
    output logic [CHANNELS-1:0]       cmp_eq,
    output logic [CHANNELS-1:0]       cmp_valid,
    output logic                      period_end
);

    localparam logic [WIDTH-1:0] PH_MAX = '1;

    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]      ph_q, ph_d;
    logic                  tick, last;
    logic                  act_mode_q;

    logic [WIDTH-1:0] act_p_q [CHANNELS];
    logic [WIDTH-1:0] act_m_q [CHANNELS];
    logic [WIDTH-1:0] acc_p_q [CHANNELS];
    logic [WIDTH-1:0] acc_m_q [CHANNELS];
    logic [WIDTH-1:0] cnt_p_q [CHANNELS];
    logic [WIDTH-1:0] cnt_m_q [CHANNELS];

    logic [WIDTH:0]   sum_p [CHANNELS];
    logic [WIDTH:0]   sum_m [CHANNELS];
    logic [WIDTH:0]   tot_p [CHANNELS];
    logic [WIDTH:0]   tot_m [CHANNELS];
    logic [CHANNELS-1:0] f_p, f_m;

    logic [CHANNELS-1:0] dac_p_q, dac_m_q, cmp_out_q, cmp_eq_q, cmp_valid_q;
    logic                period_end_q;

    always_comb begin
        tick = (pre_q >= prescale);
        last = tick && (ph_q == PH_MAX);
        pre_d = tick ? '0 : pre_q + 1'b1;
        ph_d  = tick ? ph_q + 1'b1 : ph_q;
    end

    // Stream sample for the current phase; the carry of acc+act is the sigma-delta bit.
    always_comb begin
        f_p = '0;
        f_m = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum_p[i] = {1'b0, acc_p_q[i]} + {1'b0, act_p_q[i]};
            sum_m[i] = {1'b0, acc_m_q[i]} + {1'b0, act_m_q[i]};
            if (act_mode_q) begin
                f_p[i] = sum_p[i][WIDTH];
                f_m[i] = sum_m[i][WIDTH];
            end else begin
                f_p[i] = (ph_q < act_p_q[i]);
                f_m[i] = (ph_q < act_m_q[i]);
            end
            tot_p[i] = {1'b0, cnt_p_q[i]} + {{WIDTH{1'b0}}, f_p[i]};
            tot_m[i] = {1'b0, cnt_m_q[i]} + {{WIDTH{1'b0}}, f_m[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            ph_q         <= '0;
            act_mode_q   <= 1'b0;
            period_end_q <= 1'b0;
            dac_p_q      <= '0;
            dac_m_q      <= '0;
            cmp_out_q    <= '0;
            cmp_eq_q     <= '1;
            cmp_valid_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                act_p_q[i] <= '0;
                act_m_q[i] <= '0;
                acc_p_q[i] <= '0;
                acc_m_q[i] <= '0;
                cnt_p_q[i] <= '0;
                cnt_m_q[i] <= '0;
            end
        end else begin
            pre_q        <= pre_d;
            ph_q         <= ph_d;
            period_end_q <= last;
            if (last) begin
                act_mode_q <= mode;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                // Shadow load happens even on disabled channels.
                if (last) begin
                    act_p_q[i] <= code_p[i*WIDTH +: WIDTH];
                    act_m_q[i] <= code_m[i*WIDTH +: WIDTH];
                end
                cmp_valid_q[i] <= last && en[i];
                if (!en[i]) begin
                    dac_p_q[i] <= 1'b0;
                    dac_m_q[i] <= 1'b0;
                    acc_p_q[i] <= '0;
                    acc_m_q[i] <= '0;
                    cnt_p_q[i] <= '0;
                    cnt_m_q[i] <= '0;
                end else if (tick) begin
                    dac_p_q[i] <= f_p[i];
                    dac_m_q[i] <= f_m[i];
                    if (last) begin
                        cmp_out_q[i] <= (tot_p[i] > tot_m[i]);
                        cmp_eq_q[i]  <= (tot_p[i] == tot_m[i]);
                        acc_p_q[i]   <= '0;
                        acc_m_q[i]   <= '0;
                        cnt_p_q[i]   <= '0;
                        cnt_m_q[i]   <= '0;
                    end else begin
                        cnt_p_q[i] <= tot_p[i][WIDTH-1:0];
                        cnt_m_q[i] <= tot_m[i][WIDTH-1:0];
                        if (act_mode_q) begin
                            acc_p_q[i] <= sum_p[i][WIDTH-1:0];
                            acc_m_q[i] <= sum_m[i][WIDTH-1:0];
                        end
                    end
                end
            end
        end
    end

    assign dac_p      = dac_p_q;
    assign dac_m      = dac_m_q;
    assign cmp_out    = cmp_out_q;
    assign cmp_eq     = cmp_eq_q;
    assign cmp_valid  = cmp_valid_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_dac_comp_array.sv
// Directed bench for dac_comp_array at WIDTH=4, CHANNELS=2; channel 1 stays disabled throughout.
module tb_dac_comp_array;

    localparam int WIDTH      = 4;
    localparam int CHANNELS   = 2;
    localparam int PRESCALE_W = 4;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS-1:0]       en;
    logic                      mode;
    logic [PRESCALE_W-1:0]     prescale;
    logic [CHANNELS*WIDTH-1:0] code_p;
    logic [CHANNELS*WIDTH-1:0] code_m;
    logic [CHANNELS-1:0]       dac_p;
    logic [CHANNELS-1:0]       dac_m;
    logic [CHANNELS-1:0]       cmp_out;
    logic [CHANNELS-1:0]       cmp_eq;
    logic [CHANNELS-1:0]       cmp_valid;
    logic                      period_end;

    int assertions;
    int failures;
    int nsamp;
    int ones_p1, ones_m1, v1_pulses;
    logic [255:0] bp0, bm0;

    dac_comp_array #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .prescale(prescale),
        .code_p(code_p), .code_m(code_m), .dac_p(dac_p), .dac_m(dac_m),
        .cmp_out(cmp_out), .cmp_eq(cmp_eq), .cmp_valid(cmp_valid),
        .period_end(period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_codes(input logic [3:0] p0, input logic [3:0] m0);
        code_p = {4'd9, p0};
        code_m = {4'd2, m0};
    endtask

    task automatic start_window();
        nsamp = 0;
        bp0   = '0;
        bm0   = '0;
    endtask

    task automatic sample();
        if (nsamp < 256) begin
            bp0[nsamp] = dac_p[0];
            bm0[nsamp] = dac_m[0];
        end
        nsamp++;
        ones_p1   += int'(dac_p[1]);
        ones_m1   += int'(dac_m[1]);
        v1_pulses += int'(cmp_valid[1]);
    endtask

    // Advances until the period_end pulse is visible, bounded.
    task automatic run_to_end();
        int guard;
        guard = 0;
        do begin
            clk_step();
            sample();
            guard++;
        end while (!period_end && guard < 400);
        assertions++;
        if (period_end !== 1'b1) begin
            failures++;
            $display("FAIL period_end_timeout: period_end=%b after %0d clocks, required 1", period_end, guard);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 2'b01; mode = 1'b0; prescale = 4'd0;
        set_codes(4'd5, 4'd3);
        repeat (3) clk_step();
        assertions++;
        if ({dac_p, dac_m, cmp_out, cmp_valid, period_end} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: dac_p=%b dac_m=%b cmp_out=%b cmp_valid=%b period_end=%b, required all 0",
                     dac_p, dac_m, cmp_out, cmp_valid, period_end);
        end
        assertions++;
        if (cmp_eq !== 2'b11) begin
            failures++;
            $display("FAIL reset_cmp_eq: got %b required 11", cmp_eq);
        end
        rst = 1'b0;
        start_window();
        run_to_end();
        assertions++;
        if (nsamp !== 16) begin
            failures++;
            $display("FAIL first_period_len: got %0d clocks required 16", nsamp);
        end
        assertions++;
        if (bp0[15:0] !== 16'h0000 || cmp_valid !== 2'b01 || cmp_eq[0] !== 1'b1 || cmp_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL first_period_zero_act: bits=%h valid=%b eq0=%b out0=%b, required 0000 01 1 0",
                     bp0[15:0], cmp_valid, cmp_eq[0], cmp_out[0]);
        end
    endtask

    task automatic test_pwm();
        start_window();
        run_to_end();
        assertions++;
        if (bp0[15:0] !== 16'h001F) begin
            failures++;
            $display("FAIL pwm_p_code5: got %h required 001f", bp0[15:0]);
        end
        assertions++;
        if (bm0[15:0] !== 16'h0007) begin
            failures++;
            $display("FAIL pwm_m_code3: got %h required 0007", bm0[15:0]);
        end
        assertions++;
        if (cmp_out[0] !== 1'b1 || cmp_eq[0] !== 1'b0 || cmp_valid !== 2'b01) begin
            failures++;
            $display("FAIL pwm_cmp: out0=%b eq0=%b valid=%b, required 1 0 01", cmp_out[0], cmp_eq[0], cmp_valid);
        end
    endtask

    task automatic test_sd();
        mode = 1'b1;
        set_codes(4'd8, 4'd8);
        start_window();
        clk_step();
        sample();
        assertions++;
        if (period_end !== 1'b0 || cmp_valid !== 2'b00) begin
            failures++;
            $display("FAIL pulse_width: period_end=%b cmp_valid=%b one clock later, required 0 00", period_end, cmp_valid);
        end
        run_to_end();
        assertions++;
        if (bp0[15:0] !== 16'h001F || bm0[15:0] !== 16'h0007) begin
            failures++;
            $display("FAIL mode_deferred: p=%h m=%h required 001f 0007", bp0[15:0], bm0[15:0]);
        end
        set_codes(4'd3, 4'd8);
        start_window();
        run_to_end();
        assertions++;
        if (bp0[15:0] !== 16'hAAAA || bm0[15:0] !== 16'hAAAA) begin
            failures++;
            $display("FAIL sd_code8: p=%h m=%h required aaaa aaaa", bp0[15:0], bm0[15:0]);
        end
        assertions++;
        if (cmp_eq[0] !== 1'b1 || cmp_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL sd_equal_cmp: eq0=%b out0=%b required 1 0", cmp_eq[0], cmp_out[0]);
        end
        mode = 1'b0;
        set_codes(4'd2, 4'd0);
        start_window();
        run_to_end();
        assertions++;
        if (bp0[15:0] !== 16'h8420 || bm0[15:0] !== 16'hAAAA) begin
            failures++;
            $display("FAIL sd_code3: p=%h m=%h required 8420 aaaa", bp0[15:0], bm0[15:0]);
        end
        assertions++;
        if (cmp_eq[0] !== 1'b0 || cmp_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL sd_less_cmp: eq0=%b out0=%b required 0 0", cmp_eq[0], cmp_out[0]);
        end
    endtask

    task automatic test_code_change();
        start_window();
        repeat (7) begin
            clk_step();
            sample();
        end
        set_codes(4'd12, 4'd0);
        mode = 1'b1;
        run_to_end();
        assertions++;
        if (nsamp !== 16 || bp0[15:0] !== 16'h0003 || cmp_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL code_change_deferred: n=%0d p=%h out0=%b required 16 0003 1", nsamp, bp0[15:0], cmp_out[0]);
        end
        start_window();
        run_to_end();
        assertions++;
        if (bp0[15:0] !== 16'hEEEE || bm0[15:0] !== 16'h0000) begin
            failures++;
            $display("FAIL code_change_applied: p=%h m=%h required eeee 0000", bp0[15:0], bm0[15:0]);
        end
        assertions++;
        if (cmp_out[0] !== 1'b1 || cmp_eq[0] !== 1'b0) begin
            failures++;
            $display("FAIL code_change_cmp: out0=%b eq0=%b required 1 0", cmp_out[0], cmp_eq[0]);
        end
    endtask

    task automatic test_prescale();
        prescale = 4'd3;
        mode = 1'b0;
        set_codes(4'd15, 4'd0);
        for (int k = 0; k < 3; k++) begin
            start_window();
            run_to_end();
            assertions++;
            if (nsamp !== 64) begin
                failures++;
                $display("FAIL prescale_period_len: period %0d got %0d clocks required 64", k, nsamp);
            end
        end
        assertions++;
        if (bp0[63:0] !== 64'h7FFF_FFFF_FFFF_FFF8 || bm0[63:0] !== 64'h0) begin
            failures++;
            $display("FAIL prescale_pwm15: p=%h m=%h required 7ffffffffffffff8 0", bp0[63:0], bm0[63:0]);
        end
        assertions++;
        if (cmp_out[0] !== 1'b1 || cmp_eq[0] !== 1'b0 || cmp_valid !== 2'b01) begin
            failures++;
            $display("FAIL prescale_cmp: out0=%b eq0=%b valid=%b required 1 0 01", cmp_out[0], cmp_eq[0], cmp_valid);
        end
    endtask

    task automatic test_mid_reset();
        prescale = 4'd0;
        repeat (9) clk_step();
        rst = 1'b1;
        clk_step();
        assertions++;
        if ({dac_p, dac_m, cmp_out, cmp_valid, period_end} !== 9'b0 || cmp_eq !== 2'b11) begin
            failures++;
            $display("FAIL mid_reset: dac_p=%b dac_m=%b out=%b eq=%b valid=%b pe=%b, required 00 00 00 11 00 0",
                     dac_p, dac_m, cmp_out, cmp_eq, cmp_valid, period_end);
        end
        prescale = 4'd3;
        rst = 1'b0;
        start_window();
        run_to_end();
        assertions++;
        if (nsamp !== 64 || cmp_valid !== 2'b01 || cmp_eq[0] !== 1'b1 || cmp_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL restart: n=%0d valid=%b eq0=%b out0=%b, required 64 01 1 0", nsamp, cmp_valid, cmp_eq[0], cmp_out[0]);
        end
    endtask

    task automatic test_disabled_channel();
        assertions++;
        if (ones_p1 !== 0 || ones_m1 !== 0) begin
            failures++;
            $display("FAIL ch1_disabled_dac: ones_p=%0d ones_m=%0d required 0 0", ones_p1, ones_m1);
        end
        assertions++;
        if (v1_pulses !== 0 || cmp_eq[1] !== 1'b1 || cmp_out[1] !== 1'b0) begin
            failures++;
            $display("FAIL ch1_disabled_cmp: valid_pulses=%0d eq1=%b out1=%b required 0 1 0", v1_pulses, cmp_eq[1], cmp_out[1]);
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        ones_p1    = 0;
        ones_m1    = 0;
        v1_pulses  = 0;
        nsamp      = 0;
        bp0        = '0;
        bm0        = '0;
        test_reset();
        test_pwm();
        test_sd();
        test_code_change();
        test_prescale();
        test_mid_reset();
        test_disabled_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
